// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch unit: owns the PC, fetches over valid/ready, presents to decode.
// Optional misaligned-PC fault detection when FETCH_ALIGN_CHK_EN is defined.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [15:0] imm16,
    output logic [25:0] imm26,
    input  logic [31:0] npc_in,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        halted,
    output logic        fetch_fault
);

`ifdef FETCH_ALIGN_CHK_EN
    typedef enum logic [2:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN, S_HALT, S_FAULT} state_t;
`else
    typedef enum logic [2:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN, S_HALT} state_t;
`endif

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] if_pc_q, if_pc_d;
    logic        req_valid_q, req_valid_d;
    logic        if_valid_q, if_valid_d;
    logic        halted_q, halted_d;
    logic        accept, consume, owed;
`ifdef FETCH_ALIGN_CHK_EN
    logic        fault_q, fault_d;
    logic        owe_q, owe_d;
`endif

    // Without the checker, loaded PCs are silently word-aligned.
    function automatic logic [31:0] load_pc(input logic [31:0] v);
`ifdef FETCH_ALIGN_CHK_EN
        return v;
`else
        return v & ~32'h3;
`endif
    endfunction

    assign accept  = req_valid_q & imem_req_ready;
    assign consume = if_valid_q & if_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if_pc_d = if_pc_q;
        owed    = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
        owe_d   = owe_q;
`endif
        if (redirect_valid) begin
            pc_d = load_pc(redirect_pc);
            // A response is still owed if a request is in flight and not returning this cycle;
            // a response landing in DRAIN alongside the redirect settles the debt.
            owed = ((state_q == S_REQ) && accept) ||
                   (((state_q == S_WAIT) || (state_q == S_DRAIN)) && !imem_rsp_valid);
`ifdef FETCH_ALIGN_CHK_EN
            if ((state_q == S_FAULT) && owe_q && !imem_rsp_valid) owed = 1'b1;
            if (redirect_pc[1:0] != 2'b00) begin
                state_d = S_FAULT;
                owe_d   = owed;
            end else begin
                state_d = owed ? S_DRAIN : S_REQ;
                owe_d   = 1'b0;
            end
`else
            state_d = owed ? S_DRAIN : S_REQ;
`endif
        end else begin
            case (state_q)
                S_REQ: if (accept) state_d = S_WAIT;
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        state_d = S_HOLD;
                        instr_d = imem_rsp_data;
                        if_pc_d = pc_q;
                    end
                end
                S_HOLD: begin
                    if (consume) begin
                        pc_d    = load_pc(npc_in);
                        state_d = halt ? S_HALT : S_REQ;
`ifdef FETCH_ALIGN_CHK_EN
                        if (npc_in[1:0] != 2'b00) begin
                            state_d = S_FAULT;
                            owe_d   = 1'b0;
                        end
`endif
                    end
                end
                S_DRAIN: if (imem_rsp_valid) state_d = S_REQ;
                S_HALT: state_d = S_HALT;
`ifdef FETCH_ALIGN_CHK_EN
                S_FAULT: if (imem_rsp_valid) owe_d = 1'b0;
`endif
                default: state_d = S_REQ;
            endcase
        end
        req_valid_d = (state_d == S_REQ);
        if_valid_d  = (state_d == S_HOLD);
        halted_d    = (state_d == S_HALT);
`ifdef FETCH_ALIGN_CHK_EN
        fault_d     = (state_d == S_FAULT);
`endif
    end

    // Outputs are registered from the next state, so request valid first rises one edge after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_REQ;
            pc_q        <= RESET_PC;
            instr_q     <= 32'h0;
            if_pc_q     <= 32'h0;
            req_valid_q <= 1'b0;
            if_valid_q  <= 1'b0;
            halted_q    <= 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
            fault_q     <= 1'b0;
            owe_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            if_pc_q     <= if_pc_d;
            req_valid_q <= req_valid_d;
            if_valid_q  <= if_valid_d;
            halted_q    <= halted_d;
`ifdef FETCH_ALIGN_CHK_EN
            fault_q     <= fault_d;
            owe_q       <= owe_d;
`endif
        end
    end

    assign imem_req_valid = req_valid_q;
    assign imem_req_addr  = pc_q;
    assign if_valid       = if_valid_q;
    assign if_pc          = if_pc_q;
    assign if_instr       = instr_q;
    assign imm16          = instr_q[15:0];
    assign imm26          = instr_q[25:0];
    assign halted         = halted_q;
`ifdef FETCH_ALIGN_CHK_EN
    assign fetch_fault    = fault_q;
`else
    assign fetch_fault    = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: fetch latency, back-pressure, stall, redirect, halt, alignment.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        if_valid, if_ready;
  logic [31:0] if_pc, if_instr;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] npc_in;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt, halted, fetch_fault;

  int tests = 0;
  int fails = 0;

  instr_fetch_unit #(.RESET_PC(32'h0000_3000)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_instr(if_instr),
    .imm16(imm16), .imm26(imm26), .npc_in(npc_in),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .halted(halted), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    if_ready = 1'b0; npc_in = '0; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
    repeat (3) step();
    tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL rst_req_valid got %b exp 0", imem_req_valid); end
    tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL rst_if_valid got %b exp 0", if_valid); end
    tests++; if (halted !== 1'b0 || fetch_fault !== 1'b0) begin fails++; $display("FAIL rst_halt_fault got %b%b exp 00", halted, fetch_fault); end
    tests++; if (imem_req_addr !== 32'h0000_3000) begin fails++; $display("FAIL rst_addr got %h exp 00003000", imem_req_addr); end
    tests++; if (if_instr !== 32'h0) begin fails++; $display("FAIL rst_instr got %h exp 0", if_instr); end
    rst_n = 1'b1;
    #1;
    tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL rst_rel_req_valid got %b exp 0", imem_req_valid); end
    step();
    tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_3000) begin fails++; $display("FAIL first_req got %b/%h exp 1/00003000", imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_first_fetch();
    imem_req_ready = 1'b1;
    step();  // accept edge
    tests++; if (imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin fails++; $display("FAIL ff_wait got req %b ifv %b exp 0 0", imem_req_valid, if_valid); end
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h2408_0005;
    step();
    imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    tests++; if (if_valid !== 1'b1 || if_pc !== 32'h0000_3000) begin fails++; $display("FAIL ff_present got %b/%h exp 1/00003000", if_valid, if_pc); end
    tests++; if (if_instr !== 32'h2408_0005) begin fails++; $display("FAIL ff_instr got %h exp 24080005", if_instr); end
    tests++; if (imm16 !== 16'h0005 || imm26 !== 26'h0080005) begin fails++; $display("FAIL ff_imm got %h/%h exp 0005/0080005", imm16, imm26); end
  endtask

  task automatic test_req_backpressure();
    imem_req_ready = 1'b0; if_ready = 1'b1; npc_in = 32'h0000_3004;
    step();  // consume edge
    if_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_3004 || if_valid !== 1'b0) begin
        fails++; $display("FAIL bp_hold[%0d] got req %b addr %h ifv %b exp 1 00003004 0", i, imem_req_valid, imem_req_addr, if_valid); end
      if (i < 2) step();
    end
    imem_req_ready = 1'b1;
    step();  // single accept
    tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL bp_accept got %b exp 0", imem_req_valid); end
    step();
    tests++; if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL bp_one_accept got %b exp 0", imem_req_valid); end
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h8C09_0010;
    step();
    imem_rsp_valid = 1'b0;
    tests++; if (if_valid !== 1'b1 || if_pc !== 32'h0000_3004 || if_instr !== 32'h8C09_0010) begin
      fails++; $display("FAIL bp_present got %b %h %h exp 1 00003004 8c090010", if_valid, if_pc, if_instr); end
  endtask

  task automatic test_decode_stall();
    for (int i = 0; i < 5; i++) begin
      step();
      tests++; if (if_valid !== 1'b1 || if_pc !== 32'h0000_3004 || if_instr !== 32'h8C09_0010 || imem_req_valid !== 1'b0 || imm16 !== 16'h0010) begin
        fails++; $display("FAIL stall[%0d] got ifv %b pc %h ins %h req %b imm %h", i, if_valid, if_pc, if_instr, imem_req_valid, imm16); end
    end
  endtask

  task automatic test_redirect_wait();
    if_ready = 1'b1; npc_in = 32'h0000_3008;
    step();
    if_ready = 1'b0;
    tests++; if (imem_req_addr !== 32'h0000_3008 || imem_req_valid !== 1'b1) begin fails++; $display("FAIL rw_req got %b/%h exp 1/00003008", imem_req_valid, imem_req_addr); end
    step();  // accept -> WAIT
    redirect_valid = 1'b1; redirect_pc = 32'h0000_4180;
    step();
    redirect_valid = 1'b0;
    tests++; if (imem_req_valid !== 1'b0 || imem_req_addr !== 32'h0000_4180 || if_valid !== 1'b0) begin
      fails++; $display("FAIL rw_drain got req %b addr %h ifv %b exp 0 00004180 0", imem_req_valid, imem_req_addr, if_valid); end
    step();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    step();
    imem_rsp_valid = 1'b0;
    tests++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_4180) begin
      fails++; $display("FAIL rw_rereq got ifv %b req %b addr %h exp 0 1 00004180", if_valid, imem_req_valid, imem_req_addr); end
    step();  // accept
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h3C01_0001;
    step();
    imem_rsp_valid = 1'b0;
    tests++; if (if_valid !== 1'b1 || if_pc !== 32'h0000_4180 || if_instr !== 32'h3C01_0001) begin
      fails++; $display("FAIL rw_present got %b %h %h exp 1 00004180 3c010001", if_valid, if_pc, if_instr); end
  endtask

  task automatic test_halt();
    if_ready = 1'b1; halt = 1'b1; npc_in = 32'h0000_4184;
    step();
    if_ready = 1'b0; halt = 1'b0;
    tests++; if (halted !== 1'b1 || if_valid !== 1'b0) begin fails++; $display("FAIL halt_enter got %b ifv %b exp 1 0", halted, if_valid); end
    for (int i = 0; i < 10; i++) begin
      tests++; if (imem_req_valid !== 1'b0 || halted !== 1'b1) begin fails++; $display("FAIL halt_idle[%0d] got req %b halted %b exp 0 1", i, imem_req_valid, halted); end
      step();
    end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_3000;
    step();
    redirect_valid = 1'b0;
    tests++; if (halted !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_3000) begin
      fails++; $display("FAIL halt_exit got halted %b req %b addr %h exp 0 1 00003000", halted, imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_align();
    step();  // accept
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h2409_0001;
    step();
    imem_rsp_valid = 1'b0;
    tests++; if (if_valid !== 1'b1 || if_pc !== 32'h0000_3000) begin fails++; $display("FAIL al_present got %b/%h exp 1/00003000", if_valid, if_pc); end
    if_ready = 1'b1; npc_in = 32'h0000_3006;
    step();
    if_ready = 1'b0;
`ifdef FETCH_ALIGN_CHK_EN
    for (int i = 0; i < 3; i++) begin
      tests++; if (fetch_fault !== 1'b1 || imem_req_valid !== 1'b0 || if_valid !== 1'b0) begin
        fails++; $display("FAIL al_fault[%0d] got flt %b req %b ifv %b exp 1 0 0", i, fetch_fault, imem_req_valid, if_valid); end
      step();
    end
    redirect_valid = 1'b1; redirect_pc = 32'h0000_3004;
    step();
    redirect_valid = 1'b0;
`endif
    tests++; if (fetch_fault !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_3004) begin
      fails++; $display("FAIL al_req got flt %b req %b addr %h exp 0 1 00003004", fetch_fault, imem_req_valid, imem_req_addr); end
  endtask

  task automatic test_redirect_priority();
    step();  // accept
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h0000_0020;
    step();
    imem_rsp_valid = 1'b0;
    if_ready = 1'b1; npc_in = 32'h0000_5000; redirect_valid = 1'b1; redirect_pc = 32'h0000_6000;
    step();
    if_ready = 1'b0; redirect_valid = 1'b0;
    tests++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_6000) begin
      fails++; $display("FAIL rp_consume got ifv %b req %b addr %h exp 0 1 00006000", if_valid, imem_req_valid, imem_req_addr); end
    step();  // accept -> WAIT
    redirect_valid = 1'b1; redirect_pc = 32'h0000_7000; imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_BEEF;
    step();
    redirect_valid = 1'b0; imem_rsp_valid = 1'b0;
    tests++; if (if_valid !== 1'b0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_7000) begin
      fails++; $display("FAIL rp_wait_rsp got ifv %b req %b addr %h exp 0 1 00007000", if_valid, imem_req_valid, imem_req_addr); end
    step();  // accept
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'h1111_0000;
    step();
    imem_rsp_valid = 1'b0;
    tests++; if (if_valid !== 1'b1 || if_pc !== 32'h0000_7000 || if_instr !== 32'h1111_0000) begin
      fails++; $display("FAIL rp_present got %b %h %h exp 1 00007000 11110000", if_valid, if_pc, if_instr); end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_req_backpressure();
    test_decode_stall();
    test_redirect_wait();
    test_halt();
    test_align();
    test_redirect_priority();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
